// File: rtl/mdio_link_ctrl.sv
// Clause-22 MDIO master: polls the PHY status register to configure the GMII<->RGMII converter,
// and serves one host read/write port. The host wins arbitration; a poll that comes due is latched as pending.
module mdio_link_ctrl #(
  parameter int         MDC_DIV     = 20,
  parameter logic [4:0] PHY_ADDR    = 5'd0,
  parameter int         POLL_CYCLES = 1000000,
  parameter logic [4:0] STAT_REG    = 5'd17,
  parameter int         SPD_MSB     = 15,
  parameter int         DPX_BIT     = 13,
  parameter int         LINK_BIT    = 10
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [4:0]  host_reg,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        busy,
  output logic [1:0]  speed_selection,
  output logic        duplex_mode,
  output logic        link_up,
  output logic        status_valid
);

  localparam int DW = $clog2(2 * MDC_DIV);
  localparam int TW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * MDC_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(MDC_DIV - 1);
  localparam logic [DW-1:0] DIV_RISE = DW'(MDC_DIV);
  localparam logic [TW-1:0] TMR_LAST = TW'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_FRAME, S_TAIL, S_DONE} state_t;

  state_t          state_q;
  logic [DW-1:0]   div_q;
  logic [5:0]      bit_q;
  logic [15:0]     sr_q;
  logic            we_q;
  logic            host_txn_q;
  logic [4:0]      reg_q;
  logic [TW-1:0]   timer_q;
  logic            pend_q;

  logic            div_end;
  logic [DW-1:0]   div_d;
  logic            mdc_d;
  logic [5:0]      bit_d;
  logic [15:0]     hdr_d;
  logic [1:0]      spd_fld;

  assign div_end = (div_q == DIV_LAST);
  assign div_d   = div_end ? '0 : div_q + 1'b1;
  // mdc is high for the second half of the bit period, so it is set when the next divider value reaches MDC_DIV
  assign mdc_d   = (div_q >= DIV_PRE) && !div_end;
  assign bit_d   = bit_q + 6'd1;
  // ST, OP, PHYAD, REGAD and TA as they go on the wire, MSB first
  assign hdr_d   = {2'b01, (we_q ? 2'b01 : 2'b10), PHY_ADDR, reg_q, 2'b10};
  assign spd_fld = sr_q[SPD_MSB -: 2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      div_q           <= '0;
      bit_q           <= '0;
      mdc             <= 1'b0;
      mdio_o          <= 1'b1;
      mdio_t          <= 1'b0;
      host_ack        <= 1'b0;
      host_rdata      <= '0;
      busy            <= 1'b0;
      speed_selection <= 2'b10;
      duplex_mode     <= 1'b1;
      link_up         <= 1'b0;
      status_valid    <= 1'b0;
      timer_q         <= '0;
      pend_q          <= 1'b1;
    end else begin
      host_ack <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (host_req || pend_q) begin
            state_q    <= S_PREAMBLE;
            busy       <= 1'b1;
            div_q      <= '0;
            bit_q      <= '0;
            mdc        <= 1'b0;
            mdio_o     <= 1'b1;
            mdio_t     <= 1'b1;
            host_txn_q <= host_req;
            we_q       <= host_req & host_we;
            reg_q      <= host_req ? host_reg : STAT_REG;
            sr_q       <= host_wdata;
            if (!host_req) pend_q <= 1'b0;
          end
        end
        S_PREAMBLE, S_FRAME, S_TAIL: begin
          div_q <= div_d;
          mdc   <= mdc_d;
          if (!we_q && state_q == S_FRAME && bit_q >= 6'd48 && div_q == DIV_RISE)
            sr_q <= {sr_q[14:0], mdio_i};
          if (div_end) begin
            bit_q <= bit_d;
            if (state_q == S_TAIL) begin
              state_q <= S_DONE;
              if (host_txn_q) begin
                host_ack <= 1'b1;
                if (!we_q) host_rdata <= sr_q;
              end else begin
                status_valid <= 1'b1;
                link_up      <= sr_q[LINK_BIT];
                if (sr_q[LINK_BIT] && spd_fld != 2'b11) begin
                  speed_selection <= spd_fld;
                  duplex_mode     <= sr_q[DPX_BIT];
                end
              end
            end else if (bit_q == 6'd63) begin
              state_q <= S_TAIL;
              mdio_t  <= 1'b0;
              mdio_o  <= 1'b1;
            end else if (bit_d < 6'd32) begin
              mdio_o <= 1'b1;
            end else if (bit_d < 6'd48) begin
              state_q <= S_FRAME;
              mdio_o  <= hdr_d[4'd15 - bit_d[3:0]];
              mdio_t  <= we_q || (bit_d < 6'd46);
            end else if (we_q) begin
              mdio_o <= sr_q[15];
              sr_q   <= {sr_q[14:0], 1'b0};
            end else begin
              mdio_o <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
      // Expiry after the start-of-poll clear so a same-cycle expiry is not lost
      if (timer_q == TMR_LAST) begin
        timer_q <= '0;
        pend_q  <= 1'b1;
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mdio_link_ctrl.sv
// Bench for mdio_link_ctrl: a behavioural clause-22 PHY decodes frames off the pad, a scoreboard of host
// requests and a status model checked whenever the DUT acks a host request or finishes a transaction.
module tb_mdio_link_ctrl;
  localparam int         MDC_DIV     = 2;
  localparam int         POLL_CYCLES = 400;
  localparam logic [4:0] STAT        = 5'd17;

  logic        clk = 1'b0, reset = 1'b1;
  logic        mdc, mdio_o, mdio_t, mdio_i;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [4:0]  host_reg = '0;
  logic [15:0] host_wdata = '0;
  logic        host_ack, busy, duplex_mode, link_up, status_valid;
  logic [15:0] host_rdata;
  logic [1:0]  speed_selection;

  mdio_link_ctrl #(.MDC_DIV(MDC_DIV), .PHY_ADDR(5'd0), .POLL_CYCLES(POLL_CYCLES), .STAT_REG(STAT),
                   .SPD_MSB(15), .DPX_BIT(13), .LINK_BIT(10)) dut (
    .clk(clk), .reset(reset), .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i),
    .host_req(host_req), .host_we(host_we), .host_reg(host_reg), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .busy(busy), .speed_selection(speed_selection),
    .duplex_mode(duplex_mode), .link_up(link_up), .status_valid(status_valid));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // PHY model: register file, pad with pull-up, frame decoder working on mdc edges
  logic [15:0] phy_regs [32];
  logic [15:0] ref_regs [32];
  logic        phy_drv = 1'b0, phy_bit = 1'b1;
  assign mdio_i = mdio_t ? mdio_o : (phy_drv ? phy_bit : 1'b1);

  int          bitidx = 0, last_rise = 0, frames_done = 0;
  logic [0:64] fv;
  logic        fr_we = 1'b0, mdc_prev = 1'b0;
  logic [4:0]  fr_reg;
  logic [15:0] fr_rd, fr_wd;
  logic        last_we;
  logic [4:0]  last_reg;
  logic [15:0] last_data;

  always @(negedge clk) begin
    if (reset) begin
      bitidx = 0; phy_drv = 1'b0; mdc_prev = 1'b0;
    end else begin
      if (!mdc && mdc_prev && !fr_we) begin
        if (bitidx == 46 || bitidx == 64) phy_drv = 1'b0;
        else if (bitidx == 47) begin phy_drv = 1'b1; phy_bit = 1'b0; end
        else if (bitidx >= 48 && bitidx <= 63) begin phy_drv = 1'b1; phy_bit = fr_rd[63 - bitidx]; end
      end
      if (mdc && !mdc_prev) begin
        if (bitidx > 0) chk("mdc_period", cyc - last_rise, 2 * MDC_DIV);
        last_rise = cyc;
        fv[bitidx] = mdio_i;
        chk("mdio_t_bit", mdio_t, (bitidx < 46) || (fr_we && bitidx < 64));
        if (bitidx == 45) begin
          chk("preamble", fv[0:31], 32'hFFFF_FFFF);
          chk("st", fv[32:33], 2'b01);
          chk("op_valid", (fv[34:35] == 2'b01) || (fv[34:35] == 2'b10), 1);
          chk("phyad", fv[36:40], 5'd0);
          fr_we  = (fv[34:35] == 2'b01);
          fr_reg = fv[41:45];
          if (!fr_we) fr_rd = phy_regs[fr_reg];
        end
        if (bitidx == 63 && fr_we) begin
          chk("write_ta", fv[46:47], 2'b10);
          fr_wd = fv[48:63];
          phy_regs[fr_reg] = fr_wd;
        end
        if (bitidx == 64) begin
          last_we = fr_we; last_reg = fr_reg;
          last_data = fr_we ? fr_wd : fr_rd;
          frames_done++;
          bitidx = 0;
          fr_we = 1'b0;
        end else begin
          bitidx++;
        end
      end
      mdc_prev = mdc;
    end
  end

  // Scoreboard and status model
  typedef struct packed { logic we; logic [4:0] rg; logic [15:0] wd; logic [15:0] rd; } txn_t;
  txn_t        host_q [$];
  logic        busy_prev = 1'b0, ack_seen = 1'b0;
  int          busy_rise = 0, fr_at_start = 0, n_polls = 0;
  logic [1:0]  exp_spd = 2'b10;
  logic        exp_dpx = 1'b1, exp_link = 1'b0, exp_sv = 1'b0;
  logic [15:0] exp_hrdata = '0;

  always @(negedge clk) begin
    txn_t e;
    if (reset) begin
      busy_prev = 1'b0; ack_seen = 1'b0;
      exp_spd = 2'b10; exp_dpx = 1'b1; exp_link = 1'b0; exp_sv = 1'b0; exp_hrdata = '0;
    end else begin
      if (busy && !busy_prev) begin
        busy_rise = cyc; ack_seen = 1'b0; fr_at_start = frames_done;
      end
      if (host_ack) begin
        ack_seen = 1'b1;
        if (host_q.size() == 0) chk("unexpected_host_ack", 1, 0);
        else begin
          e = host_q.pop_front();
          chk("ack_latency", cyc - busy_rise, 65 * 2 * MDC_DIV);
          chk("host_frame_seen", frames_done, fr_at_start + 1);
          chk("host_op", last_we, e.we);
          chk("host_reg", last_reg, e.rg);
          if (e.we) chk("host_wdata_on_wire", last_data, e.wd);
          else exp_hrdata = e.rd;
          chk("host_rdata", host_rdata, exp_hrdata);
        end
      end
      if (!busy && busy_prev) begin
        chk("frame_count", frames_done, fr_at_start + 1);
        if (!ack_seen) begin
          chk("poll_op", last_we, 0);
          chk("poll_reg", last_reg, STAT);
          exp_link = last_data[10];
          if (last_data[10] && last_data[15:14] != 2'b11) begin
            exp_spd = last_data[15:14]; exp_dpx = last_data[13];
          end
          exp_sv = 1'b1;
          n_polls++;
        end
        chk("link_up", link_up, exp_link);
        chk("speed_selection", speed_selection, exp_spd);
        chk("duplex_mode", duplex_mode, exp_dpx);
        chk("status_valid", status_valid, exp_sv);
        chk("host_rdata_hold", host_rdata, exp_hrdata);
      end
      busy_prev = busy;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic host_issue(input logic we, input logic [4:0] rg, input logic [15:0] wd);
    txn_t e;
    e.we = we; e.rg = rg; e.wd = wd; e.rd = ref_regs[rg];
    if (we) ref_regs[rg] = wd;
    host_q.push_back(e);
    host_we = we; host_reg = rg; host_wdata = wd; host_req = 1'b1;
  endtask

  task automatic host_wait();
    int t = 0;
    do begin tick(); t++; end while (!host_ack && t < 3000);
    if (!host_ack) begin
      chk("host_ack_timeout", host_ack, 1);
      host_q.delete();
    end
    host_req = 1'b0;
  endtask

  task automatic wait_polls(input int n);
    int target = n_polls + n;
    int t = 0;
    while (n_polls < target && t < n * 1500) begin tick(); t++; end
    chk("poll_timeout", n_polls >= target, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 1000) begin tick(); t++; end
    chk("idle_timeout", busy, 0);
  endtask

  logic [15:0] poll_vals [7];

  initial begin
    int t;
    poll_vals[0] = 16'hA400; poll_vals[1] = 16'h4000; poll_vals[2] = 16'hE400; poll_vals[3] = 16'h6400;
    poll_vals[4] = 16'h2400; poll_vals[5] = 16'h0400; poll_vals[6] = 16'h8000;
    for (int i = 0; i < 32; i++) begin
      phy_regs[i] = 16'($urandom);
      ref_regs[i] = phy_regs[i];
    end
    phy_regs[2] = 16'h0141; ref_regs[2] = 16'h0141;
    phy_regs[STAT] = 16'hA400;

    repeat (3) tick();
    chk("rst_mdc", mdc, 0);
    chk("rst_mdio_o", mdio_o, 1);
    chk("rst_mdio_t", mdio_t, 0);
    chk("rst_host_ack", host_ack, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_speed", speed_selection, 2'b10);
    chk("rst_duplex", duplex_mode, 1);
    chk("rst_link", link_up, 0);
    chk("rst_status_valid", status_valid, 0);
    reset = 1'b0;
    tick();
    chk("first_poll_start", busy, 1);
    wait_polls(1);

    // Directed status values: wait two polls so each value is surely returned once
    for (int i = 1; i < 6; i++) begin
      phy_regs[STAT] = poll_vals[i];
      wait_polls(2);
    end

    // Host write colliding with the pending post-reset poll
    wait_idle();
    reset = 1'b1;
    tick(); tick();
    host_issue(1'b1, 5'd0, 16'h1340);
    reset = 1'b0;
    host_wait();
    tick();
    chk("idle_after_host", busy, 0);
    tick();
    chk("poll_after_host", busy, 1);
    wait_polls(1);

    host_issue(1'b0, 5'd2, 16'h0000);
    host_wait();

    for (int n = 0; n < 24; n++) begin
      logic [4:0] rg;
      rg = 5'($urandom_range(0, 31));
      if (rg == STAT) rg = 5'd18;
      host_issue(1'($urandom_range(0, 1)), rg, 16'($urandom));
      host_wait();
      if ($urandom_range(0, 2) == 0) phy_regs[STAT] = poll_vals[$urandom_range(0, 6)];
      repeat ($urandom_range(0, 300)) tick();
    end

    // Reset in the middle of a host read
    wait_idle();
    host_we = 1'b0; host_reg = 5'd3; host_req = 1'b1;
    t = 0;
    while (bitidx != 40 && t < 1000) begin tick(); t++; end
    chk("reached_bit40", bitidx, 40);
    reset = 1'b1;
    host_req = 1'b0;
    tick();
    chk("abort_mdc", mdc, 0);
    chk("abort_mdio_t", mdio_t, 0);
    chk("abort_busy", busy, 0);
    chk("abort_no_ack", host_ack, 0);
    tick();
    chk("abort_no_ack2", host_ack, 0);
    reset = 1'b0;
    tick();
    chk("poll_restart", busy, 1);
    wait_polls(1);
    chk("scoreboard_drained", host_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
